dlfloat_div: RTL and testbench

Sequential DLfloat16 divider computing `q = a / b`. It is the inverse-direction companion to the DLfloat16 multiply/accumulate datapath and is used for normalisation and scaling of MAC results. The format is sign[15], exponent[14:9] with bias 31, and mantissa[8:0] with a hidden leading 1. Operands are accepted over a valid/ready handshake, and an 11-iteration restoring mantissa division runs under a small FSM. Results are presented over a second valid/ready handshake.

---
 rtl/dlfloat_div.sv | 145 ++++++++++++++
 tb/tb_dlfloat_div.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_div.sv
// Sequential DLfloat16 divider: q = a / b using an 11-step restoring mantissa
// division, with valid/ready handshakes on both the operand and the result side.
module dlfloat_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [10:0]        rem_q;
  logic [10:0]        quo_q;
  logic [3:0]         count_q;
  logic [9:0]         mb_q;
  logic               sign_q;
  logic signed [7:0]  exp_q;
  logic [15:0]        res_q;

  logic               special_s;
  logic [15:0]        special_val_s;
  logic signed [7:0]  exp_d;
  logic               ge_s;
  logic [10:0]        rem_sub_s;
  logic [10:0]        rem_d;
  logic [10:0]        quo_d;
  logic signed [7:0]  exp_norm_s;
  logic [8:0]         mant_norm_s;
  logic [15:0]        norm_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = res_q;

  // Special-case detection and biased exponent difference for the operand pair
  always_comb begin
    special_s     = 1'b0;
    special_val_s = 16'h0000;
    if ((in_a == 16'hFFFF) || (in_b == 16'hFFFF)) begin
      special_s     = 1'b1;
      special_val_s = 16'hFFFF;
    end else if (in_b[14:9] == 6'd0) begin
      special_s     = 1'b1;
      special_val_s = 16'hFFFF;
    end else if (in_a[14:9] == 6'd0) begin
      special_s     = 1'b1;
      special_val_s = 16'h0000;
    end else begin
      special_s     = 1'b0;
      special_val_s = 16'h0000;
    end
    exp_d = $signed({2'b00, in_a[14:9]}) - $signed({2'b00, in_b[14:9]}) + 8'sd31;
  end

  // One restoring-division step; rem < mb after subtraction so the shift never overflows
  always_comb begin
    ge_s      = (rem_q >= {1'b0, mb_q});
    rem_sub_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d     = {rem_sub_s[9:0], 1'b0};
    quo_d     = {quo_q[9:0], ge_s};
  end

  // Normalise the quotient and apply overflow/underflow saturation
  always_comb begin
    if (quo_q[10]) begin
      exp_norm_s  = exp_q;
      mant_norm_s = quo_q[9:1];
    end else begin
      exp_norm_s  = exp_q - 8'sd1;
      mant_norm_s = quo_q[8:0];
    end
    if (exp_norm_s >= 8'sd63) begin
      norm_d = 16'hFFFF;
    end else if (exp_norm_s <= 8'sd0) begin
      norm_d = 16'h0000;
    end else begin
      norm_d = {sign_q, exp_norm_s[5:0], mant_norm_s};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 11'd0;
      quo_q   <= 11'd0;
      count_q <= 4'd0;
      mb_q    <= 10'd0;
      sign_q  <= 1'b0;
      exp_q   <= 8'sd0;
      res_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_a[15] ^ in_b[15];
            exp_q  <= exp_d;
            mb_q   <= {1'b1, in_b[8:0]};
            if (special_s) begin
              res_q   <= special_val_s;
              state_q <= DONE;
            end else begin
              rem_q   <= {2'b01, in_a[8:0]};
              quo_q   <= 11'd0;
              count_q <= 4'd0;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 4'd1;
          if (count_q == 4'd10) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          res_q   <= norm_d;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_div.sv
// Self-checking bench for dlfloat_div: directed table, handshake/reset sequences,
// and random operands checked against an arithmetic reference model.
module tb_dlfloat_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;

  int applied;
  int miscompares;

  dlfloat_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    int          lat;
  } vec_t;

  // Quotient straight from the number format: integer division of the significands
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, q, e, ex, mant;
    logic [15:0] r;
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    if (b[14:9] == 6'd0) return 16'hFFFF;
    if (a[14:9] == 6'd0) return 16'h0000;
    ma = 512 + int'(a[8:0]);
    mb = 512 + int'(b[8:0]);
    q  = (ma * 1024) / mb;
    e  = int'(a[14:9]) - int'(b[14:9]) + 31;
    if (q >= 1024) begin
      mant = (q / 2) % 512;
      ex   = e;
    end else begin
      mant = q % 512;
      ex   = e - 1;
    end
    if (ex >= 63) return 16'hFFFF;
    if (ex <= 0) return 16'h0000;
    r = {a[15] ^ b[15], 6'(ex), 9'(mant)};
    return r;
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'hFFFF || b == 16'hFFFF || b[14:9] == 6'd0 || a[14:9] == 6'd0) return 0;
    return 12;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one division; lat is the number of edges after the accept edge at which out_q is written
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_q, input int exp_lat, input string name);
    int k;
    logic busy_ok;
    @(negedge clk);
    check({name, " in_ready before accept"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k        = 0;
    busy_ok  = 1'b1;
    while (!out_valid && k < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({name, " in_ready low while busy"}, int'(busy_ok), 1);
    check({name, " latency"}, k, exp_lat);
    check({name, " out_q"}, int'(out_q), int'(exp_q));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid drops"}, int'(out_valid), 0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [15:0] held;
    logic        stable_ok;
    logic        ra, rb;
    logic [15:0] a, b;
    int k;
    applied     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = 16'h0000;
    in_b        = 16'h0000;
    out_ready   = 1'b0;

    vecs[0] = '{16'h3E00, 16'h3E00, 16'h3E00, 12};
    vecs[1] = '{16'h4100, 16'h4000, 16'h3F00, 12};
    vecs[2] = '{16'h3E00, 16'h3F00, 16'h3CAA, 12};
    vecs[3] = '{16'hBE00, 16'h3F00, 16'hBCAA, 12};
    vecs[4] = '{16'h4000, 16'h0000, 16'hFFFF, 0};
    vecs[5] = '{16'h0000, 16'h4000, 16'h0000, 0};
    vecs[6] = '{16'hFFFF, 16'h3E00, 16'hFFFF, 0};
    vecs[7] = '{16'h8000, 16'h8000, 16'hFFFF, 0};
    vecs[8] = '{16'h7C00, 16'h3000, 16'hFFFF, 12};
    vecs[9] = '{16'h0200, 16'h7C00, 16'h0000, 12};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_q", int'(out_q), 16'h0000);
    check("reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, a competing operand is ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h4100;
    in_b     = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    in_a = 16'h3E00;
    in_b = 16'h3F00;
    k    = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp latency", k, 12);
    held      = out_q;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_q != held || !out_valid || in_ready) stable_ok = 1'b0;
    end
    check("bp held stable", int'(stable_ok), 1);
    check("bp out_q", int'(out_q), 16'h3F00);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", int'(in_ready), 1);
    check("bp release out_valid", int'(out_valid), 0);
    do_op(16'h3E00, 16'h3F00, 16'h3CAA, 12, "bp next");

    // Reset during DIV aborts the operation
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h3E00;
    in_b     = 16'h3E00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst out_q", int'(out_q), 16'h0000);
    check("midrst in_ready", int'(in_ready), 1);
    stable_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stable_ok = 1'b0;
    end
    check("midrst no stale result", int'(stable_ok), 1);
    do_op(16'h4100, 16'h4000, 16'h3F00, 12, "post reset");

    // Random operands, with occasional special encodings
    for (int i = 0; i < 150; i++) begin
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(0, 65535));
      ra = ($urandom_range(0, 15) == 0);
      rb = ($urandom_range(0, 15) == 0);
      if (ra) a[14:9] = 6'd0;
      if (rb) b = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) b[14:9] = a[14:9] - 6'($urandom_range(0, 3));
      do_op(a, b, ref_div(a, b), ref_lat(a, b), $sformatf("rand%0d a=%h b=%h", i, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
